// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: sequencer state encoding
// and default sizing constants.
package mult_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    ACK_WAIT = 3'd2,
    BUSY     = 3'd3,
    RESP     = 3'd4
  } arb_state_e;

  localparam int W_DEF       = 3;
  localparam int TIMEOUT_DEF = 32;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin priority picker. Searches req_i starting one
// position after ptr_i, wrapping, and reports the first set bit as a one-hot
// winner plus its index. Usable by any shared-resource controller.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // Rotating-priority search: the slot just after the last winner ranks highest.
  always_comb begin
    logic found;
    int   cand;
    winner_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        winner_o[cand] = 1'b1;
        idx_o          = IW'(cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier among
// N_REQ requesters. Grants one requester at a time, latches its operands,
// pulses the multiplier init, tracks the done handshake (skipping a stale
// done left over from the previous operation) and returns the product with a
// per-requester valid strobe. A watchdog turns a hung multiplier into an
// error response.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_mr,
  input  logic [N_REQ*W-1:0] req_md,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]     rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_init,
  output logic [W-1:0]       mul_mr,
  output logic [W-1:0]       mul_md,
  input  logic               mul_done,
  input  logic [2*W-1:0]     mul_pp
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);

  arb_state_e         state_q;
  logic [IW-1:0]      ptr_q;
  logic [TW-1:0]      wd_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   rsp_valid_q;
  logic [2*W-1:0]     rsp_data_q;
  logic               rsp_err_q;
  logic               busy_q;
  logic               init_q;
  logic [W-1:0]       mr_q;
  logic [W-1:0]       md_q;

  logic [N_REQ-1:0]   win;
  logic [IW-1:0]      win_idx;
  logic               any_req;
  logic [W-1:0]       mr_d;
  logic [W-1:0]       md_d;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .idx_o    (win_idx),
    .any_o    (any_req)
  );

  // Operand mux: select the candidate winner's MR/MD slices for latching at grant.
  always_comb begin
    mr_d = req_mr[int'(win_idx)*W +: W];
    md_d = req_md[int'(win_idx)*W +: W];
  end

  // Sequencer FSM with watchdog; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_RST;
      wd_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      init_q      <= 1'b0;
      mr_q        <= '0;
      md_q        <= '0;
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      rsp_valid_q <= '0;
      init_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= win;
            ptr_q   <= win_idx;
            mr_q    <= mr_d;
            md_q    <= md_d;
            init_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // init is high throughout this cycle so the multiplier's negedge sees it.
          wd_q    <= '0;
          state_q <= ACK_WAIT;
        end
        ACK_WAIT: begin
          // done may still be high from the previous op; only a clean 0 counts.
          if (wd_q == WD_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (mul_done == 1'b0) state_q <= BUSY;
          end
        end
        BUSY: begin
          // Timeout is checked first so a coincident done cannot rescue it.
          if (wd_q == WD_LAST) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state_q    <= RESP;
          end else if (mul_done == 1'b1) begin
            rsp_data_q <= mul_pp;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= gnt_q;
          gnt_q       <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign mul_init  = init_q;
  assign mul_mr    = mr_q;
  assign mul_md    = md_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a behavioural shift-add multiplier (negedge init
// sampling, done held high while idle, optional delay before leaving idle,
// optional stuck-low done) plus a vector table and hand-written sequences.
`timescale 1ns/1ps
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int TO = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_mr, req_md;
  logic [N-1:0]   gnt, rsp_valid;
  logic [2*W-1:0] rsp_data;
  logic           rsp_err, busy, mul_init;
  logic [W-1:0]   mul_mr, mul_md;
  logic           mul_done;
  logic [2*W-1:0] mul_pp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_mr    (req_mr),
    .req_md    (req_md),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_init  (mul_init),
    .mul_mr    (mul_mr),
    .mul_md    (mul_md),
    .mul_done  (mul_done),
    .mul_pp    (mul_pp)
  );

  // Multiplier model, not reset by rst.
  logic           m_done  = 1'b1;
  logic [2*W-1:0] m_pp    = '0;
  logic [2*W-1:0] m_acc   = '0;
  logic [W-1:0]   m_a     = '0;
  logic [W-1:0]   m_b     = '0;
  logic           m_run   = 1'b0;
  logic           m_fin   = 1'b0;
  int             m_bit   = 0;
  int             m_pend  = 0;
  int             m_lag   = 0;
  logic           m_stuck = 1'b0;

  assign mul_done = m_stuck ? 1'b0 : m_done;
  assign mul_pp   = m_pp;

  always @(negedge clk) begin
    if (mul_init) begin
      m_a    <= mul_mr;
      m_b    <= mul_md;
      m_pend <= m_lag + 1;
      m_run  <= 1'b0;
      m_fin  <= 1'b0;
    end else if (m_pend != 0) begin
      if (m_pend == 1) begin
        m_done <= 1'b0;
        m_run  <= 1'b1;
        m_bit  <= 0;
        m_acc  <= '0;
      end
      m_pend <= m_pend - 1;
    end else if (m_run) begin
      if (m_a[m_bit]) m_acc <= m_acc + ({3'b000, m_b} << m_bit);
      if (m_bit == W-1) begin
        m_run <= 1'b0;
        m_fin <= 1'b1;
      end
      m_bit <= m_bit + 1;
    end else if (m_fin) begin
      m_pp   <= m_acc;
      m_done <= 1'b1;
      m_fin  <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation: wait for grant, then drop the winner's request and scramble
  // operands (must not matter), then wait for the response and check it.
  task automatic do_op(input string tag, input logic [N-1:0] exp_gnt,
                       input logic [5:0] exp_data, input logic exp_err,
                       output int lat);
    int   n;
    int   inits;
    logic gnt_ok;
    n   = 0;
    lat = 0;
    while (gnt == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    req    = req & ~gnt;
    req_mr = ~req_mr;
    req_md = ~req_md;
    inits  = mul_init ? 1 : 0;
    gnt_ok = 1'b1;
    n      = 0;
    while (rsp_valid == '0 && n < 200) begin
      @(negedge clk);
      n++;
      if (mul_init) inits++;
      if (rsp_valid == '0 && gnt !== exp_gnt) gnt_ok = 1'b0;
    end
    lat = n;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(exp_gnt));
    chk({tag, " rsp_data"},  32'(rsp_data),  32'(exp_data));
    chk({tag, " rsp_err"},   32'(rsp_err),   32'(exp_err));
    chk({tag, " init_pulses"}, 32'(inits), 32'd1);
    chk({tag, " gnt_held"}, 32'(gnt_ok), 32'd1);
  endtask

  typedef struct {
    bit             rst_first;
    logic [N-1:0]   req;
    logic [N*W-1:0] mr;
    logic [N*W-1:0] md;
    logic [N-1:0]   gnt;
    logic [5:0]     data;
  } vec_t;

  vec_t tbl[11];

  initial begin : main
    int   lat;
    int   n;
    int   extra;
    // single op, simultaneous pair, then fairness over 8 ops
    tbl[0]  = '{1'b1, 4'b0010, {3'd0,3'd0,3'd5,3'd0}, {3'd0,3'd0,3'd3,3'd0}, 4'b0010, 6'd15};
    tbl[1]  = '{1'b1, 4'b0101, {3'd0,3'd2,3'd0,3'd7}, {3'd0,3'd3,3'd0,3'd7}, 4'b0001, 6'd49};
    tbl[2]  = '{1'b0, 4'b0101, {3'd0,3'd2,3'd0,3'd7}, {3'd0,3'd3,3'd0,3'd7}, 4'b0100, 6'd6};
    tbl[3]  = '{1'b1, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b0001, 6'd6};
    tbl[4]  = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b0010, 6'd10};
    tbl[5]  = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b0100, 6'd21};
    tbl[6]  = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b1000, 6'd42};
    tbl[7]  = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b0001, 6'd6};
    tbl[8]  = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b0010, 6'd10};
    tbl[9]  = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b0100, 6'd21};
    tbl[10] = '{1'b0, 4'b1111, {3'd7,3'd3,3'd2,3'd1}, {3'd6,3'd7,3'd5,3'd6}, 4'b1000, 6'd42};

    rst    = 1'b1;
    req    = '0;
    req_mr = '0;
    req_md = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset gnt",      32'(gnt),       32'd0);
    chk("reset rsp_valid",32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data),  32'd0);
    chk("reset rsp_err",  32'(rsp_err),   32'd0);
    chk("reset busy",     32'(busy),      32'd0);
    chk("reset mul_init", 32'(mul_init),  32'd0);
    chk("reset mul_mr",   32'(mul_mr),    32'd0);
    chk("reset mul_md",   32'(mul_md),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_first) begin
        req = '0;
        do_reset();
      end
      req    = tbl[i].req;
      req_mr = tbl[i].mr;
      req_md = tbl[i].md;
      do_op($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].data, 1'b0, lat);
    end
    req = '0;
    @(negedge clk);

    // Back-to-back ops with a multiplier slow to drop its stale done.
    do_reset();
    m_lag  = 3;
    req    = 4'b0001;
    req_mr = {3'd0,3'd0,3'd0,3'd3};
    req_md = {3'd0,3'd0,3'd0,3'd3};
    do_op("stale1", 4'b0001, 6'd9, 1'b0, lat);
    req    = 4'b0001;
    req_mr = {3'd0,3'd0,3'd0,3'd0};
    req_md = {3'd0,3'd0,3'd0,3'd6};
    do_op("stale2", 4'b0001, 6'd0, 1'b0, lat);
    req   = '0;
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) extra++;
    end
    chk("stale no_dup", 32'(extra), 32'd0);
    chk("stale idle busy", 32'(busy), 32'd0);
    m_lag = 0;

    // Hung multiplier: error response after the watchdog, then recovery.
    m_stuck = 1'b1;
    req     = 4'b0010;
    req_mr  = {3'd0,3'd0,3'd5,3'd0};
    req_md  = {3'd0,3'd0,3'd5,3'd0};
    do_op("timeout", 4'b0010, 6'd0, 1'b1, lat);
    chk("timeout latency", 32'(lat), 32'(TO + 2));
    m_stuck = 1'b0;
    req     = 4'b0100;
    req_mr  = {3'd0,3'd2,3'd0,3'd0};
    req_md  = {3'd0,3'd2,3'd0,3'd0};
    do_op("recover", 4'b0100, 6'd4, 1'b0, lat);
    req = '0;
    @(negedge clk);

    // Reset while the multiplier is mid-operation.
    req    = 4'b0001;
    req_mr = {3'd0,3'd0,3'd0,3'd7};
    req_md = {3'd0,3'd0,3'd0,3'd7};
    n = 0;
    while (gnt == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (3) @(negedge clk);
    chk("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst gnt0",      32'(gnt),       32'd0);
    chk("midrst busy0",     32'(busy),      32'd0);
    chk("midrst rsp_data0", 32'(rsp_data),  32'd0);
    chk("midrst rsp_valid0",32'(rsp_valid), 32'd0);
    chk("midrst mul_init0", 32'(mul_init),  32'd0);
    chk("midrst mul_mr0",   32'(mul_mr),    32'd0);
    chk("midrst mul_md0",   32'(mul_md),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    m_lag  = 2;
    req    = 4'b1000;
    req_mr = {3'd4,3'd0,3'd0,3'd0};
    req_md = {3'd4,3'd0,3'd0,3'd0};
    do_op("after_rst", 4'b1000, 6'd16, 1'b0, lat);
    req = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one shift-add multiplier (3-bit MR/MD operands, 6-bit product, init/done handshake) among N_REQ requesters. It grants one requester at a time and latches that requester's operands. It pulses the multiplier's init, tracks the done handshake (including stale-done), and returns the product with a per-requester valid pulse. It sits between client blocks and the multiplier instance; a watchdog reports a hung multiplier.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 3, operand width; product width is 2*W
TIMEOUT, 32, max cycles from init to done before error

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
req  in  N_REQ  per-requester request level
req_mr  in  N_REQ*W  packed multipliers; slice i = req_mr[i*W +: W]
req_md  in  N_REQ*W  packed multiplicands, same packing
gnt  out  N_REQ  one-hot grant, held from grant through response
rsp_valid  out  N_REQ  one-hot, one-cycle result strobe
rsp_data  out  2*W  product; held until next response
rsp_err  out  1  qualifies rsp_valid; 1 = timeout, rsp_data = 0
busy  out  1  high in any state except IDLE
mul_init  out  1  to multiplier init
mul_mr  out  W  to multiplier MR
mul_md  out  W  to multiplier MD
mul_done  in  1  from multiplier done
mul_pp  in  2*W  from multiplier pp

Behaviour:
- Reset (async): state = IDLE; gnt, rsp_valid, rsp_data, mul_init, mul_mr, mul_md = 0; rsp_err = 0; rr pointer = N_REQ-1, so req[0] wins first; watchdog = 0.
- All outputs are registered.
- IDLE: if req != 0, pick the first set bit searching from pointer+1, wrapping. Then:
  - set gnt[winner] and pointer = winner;
  - latch that requester's slices into mul_mr/mul_md;
  - go to ISSUE.
- ISSUE: mul_init = 1 for exactly this one cycle, which spans a multiplier negedge sample. Clear watchdog. Go to ACK_WAIT.
- ACK_WAIT: mul_init = 0. Wait for mul_done == 0. done stays high from the previous op until the multiplier leaves its idle state; X/1 is not accepted as 0. Then go to BUSY.
- BUSY: on mul_done == 1, set rsp_data = mul_pp, rsp_err = 0, go to RESP.
- RESP: rsp_valid[winner] = 1 for one cycle; gnt = 0. Go to IDLE. A new grant is possible on the following cycle.
- Watchdog:
  - counts every cycle in ACK_WAIT and BUSY;
  - at count == TIMEOUT-1 it forces RESP with rsp_err = 1 and rsp_data = 0;
  - a simultaneous done does not take priority over the timeout.
- mul_mr/mul_md are stable from ISSUE until the next grant.
- Operands are sampled only at grant; later changes are ignored.
- If req[winner] drops after grant, the operation is not aborted: the result is still strobed on rsp_valid[winner].
- A requester holding req high after its response competes normally and is ranked last in round-robin order.
- Simultaneous requests are served in rotating order; no requester waits more than N_REQ-1 operations.
- Reset mid-operation: the arbiter returns to IDLE immediately. The multiplier is not reset and may finish with done high; this is tolerated because the next op passes through ACK_WAIT.
- Per-op latency, IDLE (req seen) to rsp_valid: 3 cycles + multiplier latency (multiplier latency ~2..3 cycles per operand bit).
- The product is unsigned, 2*W bits; no truncation.

Decomposition:
- Shared package holds the state encoding (IDLE = 0, ISSUE = 1, ACK_WAIT = 2, BUSY = 3, RESP = 4) and the default constants W = 3 and TIMEOUT = 32.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - inputs: req and pointer; outputs: one-hot winner, index, any_req.
  - reusable by other shared-resource controllers.
- The FSM, operand mux, watchdog and response registers stay in mult_arbiter.

Test Plan:
1. Single op: req[1] with mr = 5, md = 3, real multiplier attached -> gnt = 0010, one mul_init pulse, then rsp_valid = 0010 with rsp_data = 15 and rsp_err = 0.
2. Simultaneous: req = 0101 with ops (7×7, 2×3) -> req[0] served first with rsp_data = 49, then req[2] with rsp_data = 6. gnt is always one-hot.
3. Fairness: all four req held high for 8 ops -> grant order 0,1,2,3,0,1,2,3; each rsp_valid maps to the correct product.
4. Stale done: back-to-back ops (3×3, then 0×6) -> the second op's result is taken only after done falls; rsp_data = 9, then 0, and the first result is never duplicated.
5. Timeout: multiplier stub with mul_done stuck at 0 -> rsp_valid at TIMEOUT + 2 cycles after grant, with rsp_err = 1 and rsp_data = 0; next request is served normally.
6. Reset mid-op: assert rst in BUSY -> outputs zero immediately, busy = 0; after release, req[3] with 4×4 returns 16 despite the stale done.
